ps2_rx_frame: RTL and testbench

//  PS/2 keyboard receiver: deserialises 11-bit device-to-host frames from PS2_CLK/PS2_DAT

---
 rtl/ps2_rx_frame_if.sv | 10 +
 rtl/ps2_rx_frame.sv | 111 +++++++++++
 tb/tb_ps2_rx_frame.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_frame_if.sv
// ps2_rx_frame_if: PS/2 receive pins plus decoded scan-code outputs.
interface ps2_rx_frame_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] CODEWORD;
    logic       CODEWORD_VALID;
    logic       FRAME_ERR;
    modport master (output PS2_CLK, PS2_DAT, input CODEWORD, CODEWORD_VALID, FRAME_ERR);
    modport slave  (input PS2_CLK, PS2_DAT, output CODEWORD, CODEWORD_VALID, FRAME_ERR);
endinterface

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: deserialises PS/2 device-to-host frames into one-cycle scan-code strobes.
module ps2_rx_frame #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input logic           CLOCK_50,
    input logic           RESET_N,
    ps2_rx_frame_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic [FW-1:0]          filt_cnt;
    logic                   fclk, fall_p, clk_s, dat_s;
    state_t                 state, state_n;
    logic [2:0]             bit_cnt, bit_cnt_n;
    logic [7:0]             shreg, shreg_n, codeword, codeword_n;
    logic                   pbit, pbit_n, valid, valid_n, err, err_n;
    logic [TW-1:0]          timer, timer_n;
    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];
    // fclk only follows the synced clock after FILTER_LEN consecutive differing samples
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_sync <= '1;
            dat_sync <= '1;
            filt_cnt <= '0;
            fclk     <= 1'b1;
            fall_p   <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.PS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.PS2_DAT};
            fall_p   <= 1'b0;
            if (clk_s == fclk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                fclk     <= clk_s;
                filt_cnt <= '0;
                fall_p   <= fclk;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            pbit     <= 1'b0;
            timer    <= '0;
            codeword <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            pbit     <= pbit_n;
            timer    <= timer_n;
            codeword <= codeword_n;
            valid    <= valid_n;
            err      <= err_n;
        end
    end
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        pbit_n     = pbit;
        timer_n    = (timer == TW'(TIMEOUT_CYCLES)) ? timer : timer + TW'(1);
        codeword_n = '0;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        if (state == IDLE) begin
            timer_n = '0;
            if (fall_p) begin
                err_n     = dat_s;
                state_n   = dat_s ? IDLE : DATA;
                bit_cnt_n = '0;
            end
        end else if (fall_p) begin
            timer_n = '0;
            case (state)
                DATA: begin
                    shreg_n   = {dat_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = (bit_cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    pbit_n  = dat_s;
                    state_n = STOP;
                end
                default: begin
                    state_n    = IDLE;
                    valid_n    = dat_s & (^{shreg, pbit});
                    err_n      = ~valid_n;
                    codeword_n = valid_n ? shreg : 8'h00;
                end
            endcase
        end else if (timer == TW'(TIMEOUT_CYCLES)) begin
            err_n   = 1'b1;
            state_n = IDLE;
        end
    end
    assign bus.CODEWORD       = codeword;
    assign bus.CODEWORD_VALID = valid;
    assign bus.FRAME_ERR      = err;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: drives PS/2 frames and compares received events against a frame-level model.
module tb_ps2_rx_frame;
    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;
    ps2_rx_frame_if bus ();
    ps2_rx_frame #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .bus     (bus)
    );
    localparam logic [8:0] ERR = 9'h100;
    int n_cmp = 0, n_bad = 0, cyc = 0, bad_idle = 0, err_cyc = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    always @(posedge CLOCK_50) cyc++;
    // events: {0,byte} for a valid strobe, ERR for a frame error
    always @(negedge CLOCK_50) if (RESET_N) begin
        if (bus.CODEWORD_VALID) got.push_back({1'b0, bus.CODEWORD});
        if (bus.FRAME_ERR) begin
            got.push_back(ERR);
            err_cyc = cyc;
        end
        if (bus.CODEWORD_VALID !== 1'b1 && bus.CODEWORD !== 8'h00) bad_idle++;
    end
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
    endtask
    function automatic logic [10:0] frame(input logic [7:0] b, input bit flip_par, input bit flip_stop);
        return {~flip_stop, (~^b) ^ flip_par, b, 1'b0};
    endfunction
    // bit period 100 cycles; optional 2-cycle low glitch in each high phase
    task automatic send(input logic [10:0] f, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            bus.PS2_DAT = f[i];
            if (glitch) begin
                tick(20);
                bus.PS2_CLK = 1'b0;
                tick(2);
                bus.PS2_CLK = 1'b1;
                tick(28);
            end else tick(50);
            bus.PS2_CLK = 1'b0;
            tick(50);
            bus.PS2_CLK = 1'b1;
        end
        bus.PS2_DAT = 1'b1;
    endtask
    task automatic start_test();
        got.delete();
        exp_q.delete();
        bad_idle = 0;
    endtask
    task automatic test_reset();
        tick(5);
        n_cmp += 3;
        if (bus.CODEWORD !== 8'h00) begin n_bad++; $display("FAIL reset_codeword got=%h exp=00", bus.CODEWORD); end
        if (bus.CODEWORD_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.CODEWORD_VALID); end
        if (bus.FRAME_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.FRAME_ERR); end
        @(negedge CLOCK_50) RESET_N = 1'b1;
        start_test();
        tick(30);
        n_cmp++;
        if (got.size() != 0) begin n_bad++; $display("FAIL reset_idle events got=%0d exp=0", got.size()); end
    endtask
    task automatic test_single();
        start_test();
        send(frame(8'h1C, 0, 0), 11, 0);
        exp_q.push_back(9'h01C);
        tick(30);
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL single count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL single ev%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (bad_idle != 0) begin n_bad++; $display("FAIL single idle_codeword got=%0d exp=0", bad_idle); end
    endtask
    task automatic test_back_to_back();
        start_test();
        send(frame(8'hF0, 0, 0), 11, 0);
        tick(5);
        send(frame(8'h1C, 0, 0), 11, 0);
        exp_q.push_back(9'h0F0);
        exp_q.push_back(9'h01C);
        tick(30);
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b ev%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask
    task automatic test_parity_err();
        start_test();
        send(frame(8'h1B, 1, 0), 11, 0);
        exp_q.push_back(ERR);
        tick(30);
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL parity count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL parity ev%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (bad_idle != 0) begin n_bad++; $display("FAIL parity idle_codeword got=%0d exp=0", bad_idle); end
    endtask
    task automatic test_timeout();
        int t0, d;
        start_test();
        send(frame(8'h5A, 0, 0), 6, 0);
        t0 = cyc - 50;
        tick(250);
        d = err_cyc - t0;
        send(frame(8'h23, 0, 0), 11, 0);
        exp_q.push_back(ERR);
        exp_q.push_back(9'h023);
        tick(30);
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL timeout count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL timeout ev%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (d < 200 || d > 220) begin n_bad++; $display("FAIL timeout latency got=%0d exp=200..220", d); end
    endtask
    task automatic test_glitch();
        start_test();
        send(frame(8'h2B, 0, 0), 11, 1);
        exp_q.push_back(9'h02B);
        tick(30);
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL glitch count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL glitch ev%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask
    task automatic test_reset_midframe();
        start_test();
        send(frame(8'h42, 0, 0), 5, 0);
        RESET_N = 1'b0;
        tick(3);
        n_cmp += 3;
        if (bus.CODEWORD !== 8'h00) begin n_bad++; $display("FAIL midrst_codeword got=%h exp=00", bus.CODEWORD); end
        if (bus.CODEWORD_VALID !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b exp=0", bus.CODEWORD_VALID); end
        if (bus.FRAME_ERR !== 1'b0) begin n_bad++; $display("FAIL midrst_err got=%b exp=0", bus.FRAME_ERR); end
        tick(10);
        @(negedge CLOCK_50) RESET_N = 1'b1;
        tick(100);
        send(frame(8'h42, 0, 0), 11, 0);
        exp_q.push_back(9'h042);
        tick(30);
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL midrst count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst ev%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask
    // kinds: 0-1 good, 2 bad parity, 3 bad stop, 4 lone clock fall with data high
    task automatic test_random();
        start_test();
        for (int k = 0; k < 15; k++) begin
            int kind;
            logic [7:0] b;
            kind = int'($urandom_range(0, 4));
            b = 8'($urandom);
            if (kind == 4) begin
                send(11'h7FF, 1, 0);
                exp_q.push_back(ERR);
            end else begin
                send(frame(b, kind == 2, kind == 3), 11, 1'($urandom));
                exp_q.push_back(kind < 2 ? {1'b0, b} : ERR);
            end
            tick(int'($urandom_range(5, 60)));
        end
        tick(30);
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL random count got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL random ev%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        n_cmp++;
        if (bad_idle != 0) begin n_bad++; $display("FAIL random idle_codeword got=%0d exp=0", bad_idle); end
    endtask
    initial begin
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
